voice_allocator: RTL
====================

# voice_allocator

Polyphonic voice allocator sitting directly upstream of the per-voice `adsr` envelope generators. Accepts note-on/note-off events over a valid/ready handshake and drives one gate and one note number per voice. Uses each envelope's `active` output to tell fully idle voices from releasing ones, and steals the oldest voice when none is free. Gate edges are sequenced so a retriggered or stolen voice's envelope always sees a falling edge followed by a rising edge.

## Interface
- `VOICES`, 4, number of voices (≥2).
- `NOTE_BITS`, 7, note number width (MIDI).
- `clk` in 1 — system clock; all state changes on its rising edge.
- `reset` in 1 — asynchronous, active-high; clears all state.
- `ev_valid` in 1 — event present.
- `ev_ready` out 1 — allocator can accept an event this cycle.
- `ev_on` in 1 — 1 = note-on, 0 = note-off.
- `ev_note` in NOTE_BITS — note number of the event.
- `active` in VOICES — bit i = `active` of voice i's `adsr`.
- `gate` out VOICES — bit i drives voice i's `adsr` gate.
- `voice_note` out VOICES*NOTE_BITS — voice i's note at `[i*NOTE_BITS +: NOTE_BITS]`.
- `stolen` out 1 — one-cycle pulse when a gated voice is taken for a different note.

## Operation
- Event is accepted on any rising edge with `ev_valid && ev_ready`. Events are never queued; the upstream source holds them until accepted.
- Age tracking: each voice has a `$clog2(VOICES)`-bit age. Ages always form a permutation of 0..VOICES-1. Reset sets age[i] = VOICES-1-i, so voice 0 is oldest. On assignment to voice k, every voice with age < age[k] increments and age[k] becomes 0. Note-off leaves ages unchanged.
- Note-on target selection, evaluated on the registered state at the accept edge, in priority order:
  1. Retrigger: a voice with `gate`=1 whose `voice_note` equals `ev_note`.
  2. Idle: the lowest-index voice with `gate`=0 and `active`=0.
  3. Releasing: among voices with `gate`=0, the one with the highest age.
  4. Steal: the voice with the highest age. `stolen` pulses.
- Target with `gate`=0: on the accept edge, `voice_note` is set to `ev_note`, `gate` goes to 1 and ages update. The FSM stays in READY.
- Target with `gate`=1 (retrigger or steal): on the accept edge, `gate` goes to 0, `voice_note` is set to `ev_note`, ages update and the FSM moves to RETRIG. On the next edge `gate` goes to 1 and the FSM returns to READY. `stolen` is high only during the RETRIG cycle, and only for a steal, not a retrigger.
- Note-off: clears the gate of the voice with `gate`=1 and `voice_note`=`ev_note`. If no voice matches, the event is still accepted with no effect. `voice_note` is retained so the release tail keeps its pitch.
- FSM states:
  - READY: `ev_ready`=1.
  - RETRIG: `ev_ready`=0, lasts exactly one cycle.

## Timing
- Reset values: `gate`=0, `voice_note`=0, `stolen`=0, FSM=READY, ages as above. `ev_ready`=1, decoded from FSM state, and remains 1 while `reset` is asserted; no event is accepted while `reset` is high.
- Latency, free voice: `gate` rises on the accept edge. Back-to-back events are accepted every cycle.
- Latency, retrigger/steal: `gate` is low for exactly one cycle, then high. `ev_ready` is low for that one cycle, giving one bubble.
- `active` is consumed as a same-clock registered input with no synchronisation. A voice gated on the previous edge is never idle because its `gate`=1.
- Reset asserted during RETRIG: all gates drop immediately and the pending re-gate is abandoned.
- `VOICES` equal-priority ties resolve to the lowest index, except in the age rules, which are strictly ordered.

## Test plan
- Reset, then note-on 60, 62, 64 on consecutive cycles → `gate`=4'b0111; notes 60/62/64 in voices 0/1/2; `ev_ready` constantly 1; `stolen`=0.
- Note-off 62 with `active`[1] held 1, then note-on 67 → voice 3 gated with 67; voice 1 stays `gate`=0 holding note 62.
- Voices 0–3 gated with notes 60/62/64/67, then note-on 72 → voice 0 `gate` goes 1→0 for one cycle then back to 1; `voice_note`[0]=72; `ev_ready` and `stolen` high/low per spec for exactly that cycle. Next steal then takes voice 1.
- Note-on 64 while voice 2 is gated with 64 → voice 2 gate goes 1→0→1, no other voice changes, `stolen` stays 0. Note-off 99 (unassigned) → accepted, outputs unchanged.
- Voices 1 and 3 released with `active`=1, voices 0 and 2 gated, voice 3 older than voice 1 → note-on 50 goes to voice 3 with no gate-low cycle.
- Assert `reset` during RETRIG → `gate`=0, `voice_note`=0, `stolen`=0 asynchronously. After release, note-on 60 goes to voice 0.

Source files
------------

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice allocator driving per-voice adsr gates
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   reset      asynchronous active-high reset, clears all state
//   ev_valid   note event present
//   ev_ready   allocator accepts an event this cycle (decoded from FSM state)
//   ev_on      1 = note-on, 0 = note-off
//   ev_note    note number of the event
//   active     bit i = active output of voice i's envelope
//   gate       bit i = gate to voice i's envelope
//   voice_note voice i's note at [i*NOTE_BITS +: NOTE_BITS]
//   stolen     high for the single re-gate cycle of a stolen voice
module voice_allocator #(
    parameter int VOICES    = 4,
    parameter int NOTE_BITS = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic                        ev_on,
    input  logic [NOTE_BITS-1:0]        ev_note,
    input  logic [VOICES-1:0]           active,
    output logic [VOICES-1:0]           gate,
    output logic [VOICES*NOTE_BITS-1:0] voice_note,
    output logic                        stolen
);

    localparam int AW = $clog2(VOICES);

    typedef enum logic {
        READY  = 1'b0,
        RETRIG = 1'b1
    } state_t;

    state_t              state;
    logic [VOICES-1:0]   gate_q;
    logic [NOTE_BITS-1:0] note_q [VOICES];
    // age 0 = most recently assigned, VOICES-1 = oldest; always a permutation
    logic [AW-1:0]       age_q  [VOICES];
    logic [AW-1:0]       retrig_idx;
    logic                stolen_q;

    // candidate searches over the registered state
    logic                hit_found;
    logic [AW-1:0]       hit_idx;
    logic                idle_found;
    logic [AW-1:0]       idle_idx;
    logic                rel_found;
    logic [AW-1:0]       rel_idx;
    logic [AW-1:0]       rel_age;
    logic [AW-1:0]       oldest_idx;

    // chosen note-on target
    logic [AW-1:0]       tgt;
    logic                tgt_regate;
    logic                tgt_steal;

    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        idle_found = 1'b0;
        idle_idx   = '0;
        // descending scans so the lowest matching index is the one left standing
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (gate_q[i] && (note_q[i] == ev_note)) begin
                hit_found = 1'b1;
                hit_idx   = AW'(i);
            end
            if (!gate_q[i] && !active[i]) begin
                idle_found = 1'b1;
                idle_idx   = AW'(i);
            end
        end
    end

    always_comb begin
        rel_found  = 1'b0;
        rel_idx    = '0;
        rel_age    = '0;
        oldest_idx = '0;
        // ages are unique, so strict comparisons give a single winner
        for (int i = 0; i < VOICES; i++) begin
            if (!gate_q[i] && (!rel_found || (age_q[i] > rel_age))) begin
                rel_found = 1'b1;
                rel_idx   = AW'(i);
                rel_age   = age_q[i];
            end
            if (age_q[i] == AW'(VOICES - 1)) begin
                oldest_idx = AW'(i);
            end
        end
    end

    always_comb begin
        tgt        = oldest_idx;
        tgt_regate = 1'b1;
        tgt_steal  = 1'b1;
        if (hit_found) begin
            tgt        = hit_idx;
            tgt_regate = 1'b1;
            tgt_steal  = 1'b0;
        end else if (idle_found) begin
            tgt        = idle_idx;
            tgt_regate = 1'b0;
            tgt_steal  = 1'b0;
        end else if (rel_found) begin
            tgt        = rel_idx;
            tgt_regate = 1'b0;
            tgt_steal  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= READY;
            gate_q     <= '0;
            retrig_idx <= '0;
            stolen_q   <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                note_q[i] <= '0;
                age_q[i]  <= AW'(VOICES - 1 - i);
            end
        end else begin
            case (state)
                READY: begin
                    if (ev_valid) begin
                        if (ev_on) begin
                            note_q[tgt] <= ev_note;
                            for (int i = 0; i < VOICES; i++) begin
                                if (age_q[i] < age_q[tgt]) begin
                                    age_q[i] <= age_q[i] + AW'(1);
                                end
                            end
                            age_q[tgt] <= '0;
                            if (tgt_regate) begin
                                // drop the gate now, raise it next cycle so the
                                // envelope sees a clean falling then rising edge
                                gate_q[tgt] <= 1'b0;
                                retrig_idx  <= tgt;
                                stolen_q    <= tgt_steal;
                                state       <= RETRIG;
                            end else begin
                                gate_q[tgt] <= 1'b1;
                            end
                        end else if (hit_found) begin
                            // note stays put so the release tail keeps its pitch
                            gate_q[hit_idx] <= 1'b0;
                        end
                    end
                end
                RETRIG: begin
                    gate_q[retrig_idx] <= 1'b1;
                    stolen_q           <= 1'b0;
                    state              <= READY;
                end
                default: begin
                    state <= READY;
                end
            endcase
        end
    end

    assign ev_ready = (state == READY);
    assign gate     = gate_q;
    assign stolen   = stolen_q;

    for (genvar g = 0; g < VOICES; g++) begin : g_note
        assign voice_note[g*NOTE_BITS +: NOTE_BITS] = note_q[g];
    end

endmodule
